// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//
// Multi-channel synchroniser and debouncer. Each of the WIDTH asynchronous
// inputs passes through a STAGES-deep flip-flop synchroniser. A per-channel
// counter then requires DB_CYCLES consecutive synchronised samples that
// differ from the current debounced level before the new level is accepted.
// Registered single-cycle rise and fall pulses mark every accepted change.
//
// Parameters:
//   WIDTH      number of independent channels (1..32)
//   STAGES     synchroniser depth per channel (2..4)
//   DB_CYCLES  consecutive differing samples needed to accept a level (1..65535)
//   RESET_VAL  value of synchroniser stages and levels while in reset
//
// Ports:
//   clk         single clock for all state
//   rst_n       asynchronous active-low reset
//   sig         raw asynchronous inputs, bit i is channel i
//   sig_level   registered debounced level per channel
//   sig_rise    one-cycle pulse when sig_level[i] goes 0->1
//   sig_fall    one-cycle pulse when sig_level[i] goes 1->0
//   any_change  one-cycle pulse when any channel rises or falls
// -----------------------------------------------------------------------------
module sync_debounce #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter int               DB_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_level,
    output logic [WIDTH-1:0] sig_rise,
    output logic [WIDTH-1:0] sig_fall,
    output logic             any_change
);

    localparam int             CW      = $clog2(DB_CYCLES + 1);
    // The count saturates one below DB_CYCLES: reaching it with one more
    // differing sample is the acceptance condition, so the counter never wraps.
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    // Stage 0 samples sig; stage STAGES-1 is the synchronised value.
    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]             sync;

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q, any_d;

    assign sync = sync_q[STAGES-1];

    // NOTE: every always_comb output gets a default before any branch so that
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], sig};
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == level_q[i]) begin
                // Agreement (including the end of a glitch) abandons the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Pulses are derived from the level edge being registered at the same
        // clock, so they are valid in the same cycle as the new level.
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
        any_d  = |(rise_d | fall_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of the others regardless of statement order.
    // NOTE: the per-channel counter array is small control state and is reset
    // explicitly; it must read 0 in reset so counting restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sig_level  = level_q;
    assign sig_rise   = rise_q;
    assign sig_fall   = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce
//
// Directed checks on two instances (A: WIDTH=4 STAGES=2 DB_CYCLES=4 RESET_VAL=0,
// B: WIDTH=4 STAGES=3 DB_CYCLES=1 RESET_VAL=4'b1111) followed by a random
// toggling run on instance A compared cycle by cycle to a behavioural model.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

    localparam int DB_A = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sig_a, sig_b;
    logic [3:0] level_a, rise_a, fall_a;
    logic [3:0] level_b, rise_b, fall_b;
    logic       any_a, any_b;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    sync_debounce #(
        .WIDTH(4), .STAGES(2), .DB_CYCLES(4), .RESET_VAL(4'b0000)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .sig(sig_a),
        .sig_level(level_a), .sig_rise(rise_a), .sig_fall(fall_a),
        .any_change(any_a)
    );

    sync_debounce #(
        .WIDTH(4), .STAGES(3), .DB_CYCLES(1), .RESET_VAL(4'b1111)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sig(sig_b),
        .sig_level(level_b), .sig_rise(rise_b), .sig_fall(fall_b),
        .any_change(any_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                         tag, got, exp, $time);
        end
    endtask

    // Wait for the next rising edge and sample just after it.
    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- model
    // Reference for instance A: a two-deep sample history and, per channel,
    // the length of the current run of samples that disagree with the level.
    logic [3:0] m_s0, m_s1, m_level, m_rise, m_fall;
    logic       m_any;
    int         m_run [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s0    <= 4'b0000;
            m_s1    <= 4'b0000;
            m_level <= 4'b0000;
            m_rise  <= 4'b0000;
            m_fall  <= 4'b0000;
            m_any   <= 1'b0;
            for (int c = 0; c < 4; c++) m_run[c] <= 0;
        end else begin : m_step
            logic [3:0] nl;
            int         nr [4];
            nl = m_level;
            for (int c = 0; c < 4; c++) begin
                nr[c] = (m_s1[c] != m_level[c]) ? m_run[c] + 1 : 0;
                if (nr[c] == DB_A) begin
                    nl[c] = ~m_level[c];
                    nr[c] = 0;
                end
            end
            for (int c = 0; c < 4; c++) m_run[c] <= nr[c];
            m_rise  <= nl & ~m_level;
            m_fall  <= m_level & ~nl;
            m_any   <= (nl != m_level);
            m_level <= nl;
            m_s1    <= m_s0;
            m_s0    <= sig_a;
        end
    end

    // ---------------------------------------------------------------- stimulus
    int rates [4];
    int rate_tab [4];

    initial begin
        rate_tab[0] = 2;  rate_tab[1] = 5;  rate_tab[2] = 9;  rate_tab[3] = 40;

        // Reset state.
        rst_n = 1'b0;
        sig_a = 4'b0000;
        sig_b = 4'b1111;
        #12;
        check("rst_level_a", level_a, 4'b0000);
        check("rst_pulse_a", {any_a, rise_a, fall_a}, 9'd0);
        check("rst_level_b", level_b, 4'b1111);
        check("rst_cnt_a0", dut_a.cnt_q[0], 0);

        // Single-channel rise: level appears after edge 6, pulse one cycle.
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) sig_a = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            edge_sample();
            if (k == 5) begin
                check("rise_e5_level", level_a, 4'b0000);
                check("rise_e5_pulse", rise_a, 4'b0000);
            end
            if (k == 6) begin
                check("rise_e6_level", level_a, 4'b0001);
                check("rise_e6_rise", rise_a, 4'b0001);
                check("rise_e6_any", any_a, 1'b1);
            end
            if (k == 7) begin
                check("rise_e7_level", level_a, 4'b0001);
                check("rise_e7_rise", rise_a, 4'b0000);
                check("rise_e7_any", any_a, 1'b0);
            end
        end

        // Three-cycle glitch on channel 1 is rejected.
        @(negedge clk) sig_a = 4'b0011;
        edge_sample(); edge_sample(); edge_sample();
        @(negedge clk) sig_a = 4'b0001;
        for (int k = 4; k <= 9; k++) begin
            edge_sample();
            check("glitch_level", level_a, 4'b0001);
            check("glitch_pulse", {any_a, rise_a, fall_a}, 9'd0);
            if (k == 5) check("glitch_cnt_peak", dut_a.cnt_q[1], 3);
            if (k == 6) check("glitch_cnt_clr", dut_a.cnt_q[1], 0);
        end

        // Settle at 1010, then swap to 0101 in one cycle.
        @(negedge clk) sig_a = 4'b1010;
        repeat (8) edge_sample();
        check("settle_1010", level_a, 4'b1010);
        @(negedge clk) sig_a = 4'b0101;
        for (int k = 1; k <= 7; k++) begin
            edge_sample();
            if (k == 5) check("swap_e5_level", level_a, 4'b1010);
            if (k == 6) begin
                check("swap_e6_level", level_a, 4'b0101);
                check("swap_e6_rise", rise_a, 4'b0101);
                check("swap_e6_fall", fall_a, 4'b1010);
                check("swap_e6_any", any_a, 1'b1);
            end
            if (k == 7) check("swap_e7_pulse", {any_a, rise_a, fall_a}, 9'd0);
        end

        // Reset mid-count on channel 2; instance B sees 1110 through reset.
        @(negedge clk) sig_a = 4'b0001;
        repeat (8) edge_sample();
        check("pre_rst_level", level_a, 4'b0001);
        @(negedge clk) sig_a = 4'b0101;
        repeat (4) edge_sample();
        check("pre_rst_cnt2", dut_a.cnt_q[2], 2);
        #2 rst_n = 1'b0;
        sig_b = 4'b1110;
        #1;
        check("mid_rst_level", level_a, 4'b0000);
        check("mid_rst_pulse", {any_a, rise_a, fall_a}, 9'd0);
        check("mid_rst_cnt2", dut_a.cnt_q[2], 0);
        repeat (2) begin
            edge_sample();
            check("in_rst_pulse", {any_a, rise_a, fall_a}, 9'd0);
            check("in_rst_level_b", level_b, 4'b1111);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            edge_sample();
            if (k == 3) begin
                check("b_e3_level", level_b, 4'b1111);
                check("b_e3_fall", fall_b, 4'b0000);
            end
            if (k == 4) begin
                check("b_e4_level", level_b, 4'b1110);
                check("b_e4_fall", fall_b, 4'b0001);
                check("b_e4_rise", rise_b, 4'b0000);
                check("b_e4_any", any_b, 1'b1);
            end
            if (k == 5) begin
                check("a_post_e5_level", level_a, 4'b0000);
                check("a_post_e5_pulse", rise_a, 4'b0000);
                check("b_e5_fall", fall_b, 4'b0000);
            end
            if (k == 6) begin
                check("a_post_e6_level", level_a, 4'b0101);
                check("a_post_e6_rise", rise_a, 4'b0101);
            end
            if (k == 7) check("a_post_e7_rise", rise_a, 4'b0000);
        end

        // Random toggling against the model; a fresh reset aligns both.
        @(negedge clk) rst_n = 1'b0;
        sig_a = 4'b0000;
        @(negedge clk) rst_n = 1'b1;
        model_on = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            check("rnd_level", level_a, m_level);
            check("rnd_rise", rise_a, m_rise);
            check("rnd_fall", fall_a, m_fall);
            check("rnd_any", any_a, m_any);
            for (int c = 0; c < 4; c++) begin
                rates[c] = rate_tab[(c + cyc / 2500) % 4];
                if ($urandom_range(rates[c] - 1, 0) == 0) sig_a[c] = ~sig_a[c];
            end
        end
        model_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
